// File: rtl/lsu_wb.sv
// Wishbone load/store unit: one request at a time, lane-aligned classic cycles,
// bounded retry on rty_i, bus-error and no-response timeout reporting.
module lsu_wb #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [1:0]          req_size_i,
  input  logic                req_signed_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [DATA_W-1:0]   resp_rdata_o,
  output logic [1:0]          resp_err_o,
  output logic                cyc_o,
  output logic                stb_o,
  output logic                we_o,
  output logic [ADDR_W-1:0]   adr_o,
  output logic [DATA_W/8-1:0] sel_o,
  output logic [DATA_W-1:0]   dat_o,
  input  logic [DATA_W-1:0]   dat_i,
  input  logic                ack_i,
  input  logic                err_i,
  input  logic                rty_i
);
  localparam int SEL_W = DATA_W / 8;
  localparam int OFF_W = $clog2(SEL_W);
  localparam int RTY_W = $clog2(MAX_RETRY + 2);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] E_OK = 2'd0, E_MISALIGN = 2'd1, E_BUS = 2'd2, E_TMO = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_BACKOFF, S_RESP} state_e;

  state_e              state_q, state_d;
  logic                we_q, signed_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [RTY_W-1:0]    retry_q, retry_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          err_q, err_d;
  logic [OFF_W-1:0]    off_q;
  logic                accept, bus;

  function automatic logic misaligned(input logic [1:0] size, input logic [OFF_W-1:0] off);
    logic [OFF_W-1:0] low;
    low = OFF_W'((4'd1 << size) - 4'd1);
    return (|(off & low)) || (DATA_W == 32 && size == 2'd3);
  endfunction

  function automatic logic [SEL_W-1:0] sel_mask(input logic [1:0] size, input logic [OFF_W-1:0] off);
    logic [SEL_W-1:0] m;
    case (size)
      2'd0:    m = SEL_W'(1);
      2'd1:    m = SEL_W'(3);
      2'd2:    m = SEL_W'(15);
      default: m = '1;
    endcase
    return m << off;
  endfunction

  // Shift the addressed lane down, then extend by shifting it to the top and back.
  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] d, input logic [1:0] size,
                                                 input logic [OFF_W-1:0] off, input logic sgn);
    logic [DATA_W-1:0]        f, top;
    logic signed [DATA_W-1:0] s;
    int                       sh;
    f = d >> {off, 3'b000};
    if ((8 << size) >= DATA_W) return f;
    sh  = DATA_W - (8 << size);
    top = f << sh;
    s   = $signed(top) >>> sh;
    return sgn ? $unsigned(s) : (top >> sh);
  endfunction

  assign accept = (state_q == S_IDLE) && req_valid_i;
  assign bus    = (state_q == S_BUS);
  assign off_q  = addr_q[OFF_W-1:0];

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    tmo_d   = tmo_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (req_valid_i) begin
        retry_d = '0;
        tmo_d   = '0;
        rdata_d = '0;
        if (misaligned(req_size_i, req_addr_i[OFF_W-1:0])) begin
          state_d = S_RESP;
          err_d   = E_MISALIGN;
        end else begin
          state_d = S_BUS;
          err_d   = E_OK;
        end
      end
      S_BUS: begin
        if (err_i) begin
          state_d = S_RESP;
          err_d   = E_BUS;
        end else if (ack_i) begin
          state_d = S_RESP;
          err_d   = E_OK;
          rdata_d = we_q ? '0 : load_ext(dat_i, size_q, off_q, signed_q);
        end else if (rty_i) begin
          if (retry_q == RTY_W'(MAX_RETRY)) begin
            state_d = S_RESP;
            err_d   = E_BUS;
          end else begin
            retry_d = retry_q + RTY_W'(1);
            state_d = S_BACKOFF;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d = S_RESP;
          err_d   = E_TMO;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_BACKOFF: begin
        tmo_d   = '0;
        state_d = S_BUS;
      end
      default: if (resp_ready_i) begin
        state_d = S_IDLE;
        retry_d = '0;
        tmo_d   = '0;
        rdata_d = '0;
        err_d   = E_OK;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      retry_q  <= '0;
      tmo_q    <= '0;
      rdata_q  <= '0;
      err_q    <= E_OK;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q     <= req_we_i;
        signed_q <= req_signed_i;
        size_q   <= req_size_i;
        addr_q   <= req_addr_i;
        wdata_q  <= req_wdata_i;
      end
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign cyc_o        = bus;
  assign stb_o        = bus;
  assign we_o         = bus & we_q;
  assign adr_o        = bus ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign sel_o        = bus ? sel_mask(size_q, off_q) : '0;
  assign dat_o        = bus ? (wdata_q << {off_q, 3'b000}) : '0;
endmodule

// File: tb/tb_lsu_wb.sv
// Bench for lsu_wb: a 32-bit and a 64-bit instance driven through one request
// task; expectations come from a byte-lane arithmetic model of the access.
module tb_lsu_wb;
  localparam int MAX_RETRY = 3;
  localparam int TIMEOUT   = 255;

  logic        clk, rst_n, use64;
  logic        req_valid, req_we, req_signed, resp_ready, ack, err, rty;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, dat_in;

  logic        a_ready, a_rv, a_cyc, a_stb, a_we;
  logic [31:0] a_rdata, a_adr, a_dat;
  logic [1:0]  a_err;
  logic [3:0]  a_sel;
  logic        b_ready, b_rv, b_cyc, b_stb, b_we;
  logic [63:0] b_rdata, b_dat;
  logic [31:0] b_adr;
  logic [1:0]  b_err;
  logic [7:0]  b_sel;

  logic        o_ready, o_rv, o_cyc, o_stb, o_we;
  logic [63:0] o_rdata, o_dat;
  logic [31:0] o_adr;
  logic [1:0]  o_err;
  logic [7:0]  o_sel;

  int checks = 0;
  int failures = 0;

  lsu_wb #(.DATA_W(32), .ADDR_W(32), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid & ~use64), .req_ready_o(a_ready),
    .req_we_i(req_we), .req_size_i(req_size), .req_signed_i(req_signed), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata[31:0]), .resp_valid_o(a_rv), .resp_ready_i(resp_ready),
    .resp_rdata_o(a_rdata), .resp_err_o(a_err), .cyc_o(a_cyc), .stb_o(a_stb), .we_o(a_we),
    .adr_o(a_adr), .sel_o(a_sel), .dat_o(a_dat), .dat_i(dat_in[31:0]),
    .ack_i(ack), .err_i(err), .rty_i(rty));

  lsu_wb #(.DATA_W(64), .ADDR_W(32), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)) dut64 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid & use64), .req_ready_o(b_ready),
    .req_we_i(req_we), .req_size_i(req_size), .req_signed_i(req_signed), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .resp_valid_o(b_rv), .resp_ready_i(resp_ready),
    .resp_rdata_o(b_rdata), .resp_err_o(b_err), .cyc_o(b_cyc), .stb_o(b_stb), .we_o(b_we),
    .adr_o(b_adr), .sel_o(b_sel), .dat_o(b_dat), .dat_i(dat_in),
    .ack_i(ack), .err_i(err), .rty_i(rty));

  always_comb begin
    if (use64) begin
      o_ready = b_ready; o_rv = b_rv; o_cyc = b_cyc; o_stb = b_stb; o_we = b_we;
      o_rdata = b_rdata; o_dat = b_dat; o_adr = b_adr; o_err = b_err; o_sel = b_sel;
    end else begin
      o_ready = a_ready; o_rv = a_rv; o_cyc = a_cyc; o_stb = a_stb; o_we = a_we;
      o_rdata = {32'd0, a_rdata}; o_dat = {32'd0, a_dat}; o_adr = a_adr; o_err = a_err;
      o_sel = {4'd0, a_sel};
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, o_ready, 1);
    chk({tag, "_rv"}, o_rv, 0);
    chk({tag, "_bus"}, {o_cyc, o_stb, o_we, o_sel}, 0);
    chk({tag, "_adr"}, o_adr, 0);
    chk({tag, "_dat"}, o_dat, 0);
    chk({tag, "_resp"}, {o_err, o_rdata}, 0);
  endtask

  // fin: 0 = ack, 1 = err, 2 = never terminate. n_rty rty_i responses come first.
  task automatic txn(input bit w64, input bit we, input logic [1:0] size, input bit sgn,
                     input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] rd,
                     input int n_rty, input int fin, input int hold,
                     output logic [63:0] got_rdata, output logic [1:0] got_err);
    longint unsigned dmask, fm, exp_sel, exp_dat, exp_rd;
    int nb, bytes, off, phases, k, cnt, exp_phases;
    bit mis, done;
    logic [1:0] exp_err;
    logic [63:0] held;
    nb    = w64 ? 8 : 4;
    bytes = 1 << size;
    off   = int'(addr) % nb;
    mis   = (bytes > nb) || (off % bytes != 0);
    dmask = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
    exp_sel = ((64'd1 << bytes) - 1) << off;
    exp_dat = (wdata << (8 * off)) & dmask;
    exp_rd  = ((rd & dmask) >> (8 * off));
    if (bytes < nb) begin
      fm = (64'd1 << (8 * bytes)) - 1;
      exp_rd = exp_rd & fm;
      if (sgn && ((exp_rd >> (8 * bytes - 1)) & 1) == 1) exp_rd = (exp_rd | ~fm) & dmask;
    end
    if (we) exp_rd = 0;
    if (mis) exp_err = 2'd1;
    else if (n_rty > MAX_RETRY || fin == 1) exp_err = 2'd2;
    else if (fin == 2) exp_err = 2'd3;
    else exp_err = 2'd0;
    if (exp_err != 2'd0) exp_rd = 0;
    exp_phases = (n_rty > MAX_RETRY ? MAX_RETRY : n_rty) + 1;

    use64 = w64; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    if (mis) begin
      chk("mis_cyc", o_cyc, 0);
    end else begin
      chk("bus_cyc_stb", {o_cyc, o_stb}, 2'b11);
      chk("bus_we", o_we, we);
      chk("bus_adr", o_adr, addr - 32'(off));
      chk("bus_sel", o_sel, exp_sel);
      chk("bus_dat", o_dat, exp_dat);
      chk("bus_ready", o_ready, 0);
      phases = 0; k = 0; done = 0;
      while (!done) begin
        phases++;
        if (k < n_rty) begin
          rty = 1'b1; step(); rty = 1'b0; k++;
          if (k > MAX_RETRY) done = 1;
          else begin
            chk("backoff_cyc", o_cyc, 0);
            step();
            chk("rebus_cyc", o_cyc, 1);
          end
        end else begin
          done = 1;
          if (fin == 0) begin
            ack = 1'b1; dat_in = rd; step(); ack = 1'b0; dat_in = {$urandom, $urandom};
          end else if (fin == 1) begin
            err = 1'b1; step(); err = 1'b0;
          end else begin
            cnt = 0;
            while (o_cyc && cnt < 1000) begin step(); cnt++; end
            chk("timeout_cycles", cnt, TIMEOUT);
          end
        end
      end
      chk("bus_phases", phases, exp_phases);
      chk("bus_dropped", o_cyc, 0);
    end
    chk("resp_valid", o_rv, 1);
    chk("resp_err", o_err, exp_err);
    chk("resp_rdata", o_rdata, exp_rd);
    got_rdata = o_rdata; got_err = o_err;
    held = o_rdata;
    for (int i = 0; i < hold; i++) begin
      ack = $urandom_range(0, 1); err = $urandom_range(0, 1); rty = $urandom_range(0, 1);
      step();
      chk("resp_hold", {o_rv, o_err, o_rdata}, {1'b1, exp_err, held});
    end
    ack = 1'b0; err = 1'b0; rty = 1'b0;
    resp_ready = 1'b1; step(); resp_ready = 1'b0;
    chk("after_resp", {o_rv, o_ready}, 2'b01);
  endtask

  logic [63:0] rdv;
  logic [1:0]  ev;

  initial begin
    rst_n = 1'b0; use64 = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_signed = 1'b0;
    req_size = 2'd0; req_addr = '0; req_wdata = '0; dat_in = '0;
    resp_ready = 1'b0; ack = 1'b0; err = 1'b0; rty = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("rst32");
    use64 = 1'b1; #1;
    chk_idle_outputs("rst64");
    #2 rst_n = 1'b1;
    step();

    txn(0, 0, 2'd2, 0, 32'h1000, 0, 64'hDEADBEEF, 0, 0, 0, rdv, ev);
    chk("lw_value", {ev, rdv}, {2'd0, 64'hDEADBEEF});
    txn(0, 0, 2'd0, 1, 32'h1003, 0, 64'h80123456, 0, 0, 1, rdv, ev);
    chk("lb_value", rdv, 64'hFFFFFF80);
    txn(0, 0, 2'd0, 0, 32'h1003, 0, 64'h80123456, 0, 0, 0, rdv, ev);
    chk("lbu_value", rdv, 64'h80);
    txn(1, 1, 2'd1, 0, 32'h2006, 64'hABCD, 0, 0, 0, 2, rdv, ev);
    chk("sh64_err", ev, 0);
    txn(0, 1, 2'd2, 0, 32'h1002, 64'h1234, 0, 0, 0, 1, rdv, ev);
    chk("sw_mis_err", ev, 1);
    txn(0, 0, 2'd3, 0, 32'h1000, 0, 0, 0, 0, 0, rdv, ev);
    chk("ld32_mis_err", ev, 1);
    txn(0, 0, 2'd2, 0, 32'h1000, 0, 0, 4, 0, 0, rdv, ev);
    chk("rty4_err", ev, 2);
    txn(0, 0, 2'd2, 0, 32'h1000, 0, 64'h55AA, 2, 0, 0, rdv, ev);
    chk("rty2_ack_err", ev, 0);
    txn(0, 0, 2'd2, 0, 32'h1000, 0, 0, 0, 2, 0, rdv, ev);
    chk("timeout_err", ev, 3);
    txn(1, 0, 2'd3, 1, 32'h3000, 0, 64'h8123_4567_89AB_CDEF, 0, 0, 0, rdv, ev);
    chk("ld64_value", rdv, 64'h8123_4567_89AB_CDEF);
    txn(1, 0, 2'd2, 1, 32'h3004, 0, 64'h8123_4567_0000_0000, 1, 1, 0, rdv, ev);
    chk("lw64_err_term", ev, 2);

    // Reset asserted in the middle of a bus cycle.
    use64 = 1'b0; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h40; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("pre_rst_cyc", o_cyc, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc", o_cyc, 0);
    #3 rst_n = 1'b1;
    step();
    chk("rst_release", {o_ready, o_cyc, o_rv}, 3'b100);

    for (int i = 0; i < 60; i++) begin
      bit         w64, we, sgn;
      logic [1:0] sz;
      logic [31:0] a;
      int          nr, fn;
      w64 = i[0];
      we  = $urandom_range(0, 1);
      sgn = $urandom_range(0, 1);
      sz  = 2'($urandom_range(0, 3));
      a   = $urandom & 32'hFFFF;
      if ($urandom_range(0, 7) != 0) a = a & ~((32'd1 << sz) - 1);
      nr  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : 0;
      fn  = ($urandom_range(0, 5) == 0) ? 1 : 0;
      txn(w64, we, sz, sgn, a, {$urandom, $urandom}, {$urandom, $urandom}, nr, fn,
          $urandom_range(0, 2), rdv, ev);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
